sargantana_icache_req_pipe: RTL and testbench

Parametrised elastic request pipeline for the instruction cache. Replaces fixed single-stage flop banks with DEPTH valid/ready stages carrying request metadata (idx, vpn, tag, replacement way). Adds kill and a translation hold at the tail that captures the MMU response and presents one consolidated request to the tag-compare/fill logic.

---
 rtl/sargantana_icache_req_pipe.sv | 140 ++++++++++++++
 tb/tb_sargantana_icache_req_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_req_pipe.sv
// Elastic DEPTH-stage icache request pipe with kill and a tail translation hold; latency DEPTH+1 cycles.
// Backpressure: ready/valid per stage, tail holds until MMU resolves and consumer accepts.
module sargantana_icache_req_pipe #(
    parameter int ICACHE_N_WAY     = 4,
    parameter int PPN_BIT_SIZE     = 20,
    parameter int ICACHE_TAG_WIDTH = 20,
    parameter int IDX_BITS_SIZE    = 12,
    parameter int VPN_BITS_SIZE    = 28,
    parameter int DEPTH            = 2,
    localparam int WAY_W           = $clog2(ICACHE_N_WAY),
    localparam int OCC_W           = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [IDX_BITS_SIZE-1:0]    in_idx_i,
    input  logic [VPN_BITS_SIZE-1:0]    in_vpn_i,
    input  logic [ICACHE_TAG_WIDTH-1:0] in_tag_i,
    input  logic [WAY_W-1:0]            in_way_i,
    input  logic                        kill_i,
    input  logic                        mmu_tresp_miss_i,
    input  logic                        mmu_tresp_ptw_v_i,
    input  logic [PPN_BIT_SIZE-1:0]     mmu_tresp_ppn_i,
    input  logic                        mmu_tresp_xcpt_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [IDX_BITS_SIZE-1:0]    out_idx_o,
    output logic [VPN_BITS_SIZE-1:0]    out_vpn_o,
    output logic [ICACHE_TAG_WIDTH-1:0] out_tag_o,
    output logic [WAY_W-1:0]            out_way_o,
    output logic [PPN_BIT_SIZE-1:0]     out_ppn_o,
    output logic                        out_xcpt_o,
    output logic [OCC_W-1:0]            occupancy_o
);

    typedef struct packed {
        logic [IDX_BITS_SIZE-1:0]    idx;
        logic [VPN_BITS_SIZE-1:0]    vpn;
        logic [ICACHE_TAG_WIDTH-1:0] tag;
        logic [WAY_W-1:0]            way;
    } req_t;

    logic [DEPTH-1:0]        vld_q, vld_d;
    req_t [DEPTH-1:0]        pl_q, pl_d;
    logic                    xlat_done_q, xlat_done_d;
    logic [PPN_BIT_SIZE-1:0] ppn_q, ppn_d;
    logic                    xcpt_q, xcpt_d;

    logic [DEPTH-1:0] adv;
    logic             out_fire;
    logic             in_fire;
    logic             resolve;
    req_t             in_req;

    assign in_req      = '{idx: in_idx_i, vpn: in_vpn_i, tag: in_tag_i, way: in_way_i};
    assign out_valid_o = vld_q[DEPTH-1] & xlat_done_q & ~kill_i;
    assign out_fire    = out_valid_o & out_ready_i;
    assign in_ready_o  = ~vld_q[0] | adv[0];
    assign in_fire     = in_valid_i & in_ready_o & ~kill_i;
    assign resolve     = vld_q[DEPTH-1] & ~xlat_done_q & (~mmu_tresp_miss_i | mmu_tresp_ptw_v_i);

    // Advance chain walks from the tail back, so a firing tail lets every full stage shift at once.
    always_comb begin
        logic a;
        adv        = '0;
        a          = out_fire;
        adv[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a      = vld_q[i] & (~vld_q[i+1] | a);
            adv[i] = a;
        end
    end

    always_comb begin
        vld_d = vld_q;
        pl_d  = pl_q;
        if (in_fire) begin
            vld_d[0] = 1'b1;
            pl_d[0]  = in_req;
        end else if (adv[0]) begin
            vld_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                vld_d[i] = 1'b1;
                pl_d[i]  = pl_q[i-1];
            end else if (adv[i]) begin
                vld_d[i] = 1'b0;
            end
        end
        if (kill_i) begin
            vld_d = '0;
        end
    end

    always_comb begin
        xlat_done_d = xlat_done_q;
        ppn_d       = ppn_q;
        xcpt_d      = xcpt_q;
        if (kill_i || out_fire) begin
            xlat_done_d = 1'b0;
        end else if (resolve) begin
            xlat_done_d = 1'b1;
            ppn_d       = mmu_tresp_ppn_i;
            xcpt_d      = mmu_tresp_xcpt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q       <= '0;
            pl_q        <= '0;
            xlat_done_q <= 1'b0;
            ppn_q       <= '0;
            xcpt_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            pl_q        <= pl_d;
            xlat_done_q <= xlat_done_d;
            ppn_q       <= ppn_d;
            xcpt_q      <= xcpt_d;
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_o = occupancy_o + OCC_W'(vld_q[i]);
        end
    end

    assign out_idx_o  = pl_q[DEPTH-1].idx;
    assign out_vpn_o  = pl_q[DEPTH-1].vpn;
    assign out_tag_o  = pl_q[DEPTH-1].tag;
    assign out_way_o  = pl_q[DEPTH-1].way;
    assign out_ppn_o  = ppn_q;
    assign out_xcpt_o = xcpt_q;

endmodule

// File: tb/tb_sargantana_icache_req_pipe.sv
// Directed bench for sargantana_icache_req_pipe at DEPTH=2.
module tb_sargantana_icache_req_pipe;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] in_idx_i;
    logic [27:0] in_vpn_i;
    logic [19:0] in_tag_i;
    logic [1:0]  in_way_i;
    logic        kill_i;
    logic        mmu_tresp_miss_i;
    logic        mmu_tresp_ptw_v_i;
    logic [19:0] mmu_tresp_ppn_i;
    logic        mmu_tresp_xcpt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] out_idx_o;
    logic [27:0] out_vpn_o;
    logic [19:0] out_tag_o;
    logic [1:0]  out_way_o;
    logic [19:0] out_ppn_o;
    logic        out_xcpt_o;
    logic [1:0]  occupancy_o;

    sargantana_icache_req_pipe #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_idx_i(in_idx_i), .in_vpn_i(in_vpn_i), .in_tag_i(in_tag_i), .in_way_i(in_way_i),
        .kill_i(kill_i),
        .mmu_tresp_miss_i(mmu_tresp_miss_i), .mmu_tresp_ptw_v_i(mmu_tresp_ptw_v_i),
        .mmu_tresp_ppn_i(mmu_tresp_ppn_i), .mmu_tresp_xcpt_i(mmu_tresp_xcpt_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_idx_o(out_idx_o), .out_vpn_o(out_vpn_o), .out_tag_o(out_tag_o), .out_way_o(out_way_o),
        .out_ppn_o(out_ppn_o), .out_xcpt_o(out_xcpt_o), .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] idx;
        logic [27:0] vpn;
        logic [19:0] tag;
        logic [1:0]  way;
        logic [19:0] ppn;
        logic        xcpt;
        int          cyc;
    } obs_t;

    obs_t obs[$];
    int   cyc = 0;
    int   fire_cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Records every accepted output; tests inspect the queue afterwards.
    always @(negedge clk_i) begin
        if (rstn_i && out_valid_o && out_ready_i)
            obs.push_back('{out_idx_o, out_vpn_o, out_tag_o, out_way_o, out_ppn_o, out_xcpt_o, cyc});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [27:0] vpn_of(input logic [11:0] idx);
        return 28'h0ABC000 | {16'h0, idx};
    endfunction

    function automatic logic [19:0] tag_of(input logic [11:0] idx);
        return 20'hF0000 | {8'h0, idx};
    endfunction

    // Presents one request and returns just after the edge at which it was accepted.
    task automatic send(input logic [11:0] idx);
        int n = 0;
        in_valid_i = 1'b1;
        in_idx_i   = idx;
        in_vpn_i   = vpn_of(idx);
        in_tag_i   = tag_of(idx);
        in_way_i   = idx[1:0];
        @(negedge clk_i);
        while (!in_ready_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 60) check("send_timeout", 64'(n), 64'd0);
        fire_cyc = cyc;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int t0;
        rstn_i = 1'b0; in_valid_i = 1'b0; in_idx_i = '0; in_vpn_i = '0; in_tag_i = '0; in_way_i = '0;
        kill_i = 1'b0; mmu_tresp_miss_i = 1'b0; mmu_tresp_ptw_v_i = 1'b0;
        mmu_tresp_ppn_i = 20'h12345; mmu_tresp_xcpt_i = 1'b0; out_ready_i = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        check("rst_in_ready",  64'(in_ready_o),  64'd1);
        check("rst_out_ppn",   64'(out_ppn_o),   64'd0);
        step(2);
        rstn_i = 1'b1;
        step(1);

        // Always-hit MMU, four back-to-back requests.
        obs.delete();
        send(12'h001);
        t0 = fire_cyc;
        send(12'h002);
        send(12'h003);
        send(12'h004);
        step(15);
        check("hit_count", 64'(obs.size()), 64'd4);
        if (obs.size() == 4) begin
            check("hit_first_latency", 64'(obs[0].cyc - t0), 64'(DEPTH + 1));
            for (int k = 0; k < 4; k++) begin
                logic [11:0] e;
                e = 12'(k + 1);
                check("hit_idx", 64'(obs[k].idx), 64'(e));
                check("hit_vpn", 64'(obs[k].vpn), 64'(vpn_of(e)));
                check("hit_tag", 64'(obs[k].tag), 64'(tag_of(e)));
                check("hit_way", 64'(obs[k].way), 64'(e[1:0]));
                check("hit_ppn", 64'(obs[k].ppn), 64'h12345);
            end
        end

        // TLB miss holds the tail until the walker answers.
        obs.delete();
        mmu_tresp_miss_i = 1'b1;
        mmu_tresp_ppn_i  = 20'h00000;
        send(12'h011);
        send(12'h012);
        in_valid_i = 1'b1; in_idx_i = 12'h013;
        repeat (5) @(negedge clk_i);
        check("miss_in_ready",  64'(in_ready_o),  64'd0);
        check("miss_occupancy", 64'(occupancy_o), 64'd2);
        check("miss_out_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i); #1;
        mmu_tresp_ptw_v_i = 1'b1;
        mmu_tresp_ppn_i   = 20'hABCDE;
        send(12'h013);
        step(15);
        mmu_tresp_miss_i = 1'b0; mmu_tresp_ptw_v_i = 1'b0;
        check("miss_count", 64'(obs.size()), 64'd3);
        if (obs.size() == 3) begin
            check("miss_first_ppn", 64'(obs[0].ppn), 64'hABCDE);
            for (int k = 0; k < 3; k++)
                check("miss_order", 64'(obs[k].idx), 64'(12'h011 + k));
        end

        // Consumer stall with the pipe full.
        obs.delete();
        mmu_tresp_ppn_i = 20'h0000F;
        out_ready_i = 1'b0;
        send(12'h021);
        send(12'h022);
        in_valid_i = 1'b1; in_idx_i = 12'h023;
        step(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("stall_out_valid", 64'(out_valid_o), 64'd1);
            check("stall_out_idx",   64'(out_idx_o),   64'h021);
            check("stall_in_ready",  64'(in_ready_o),  64'd0);
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        send(12'h023);
        step(15);
        check("stall_count", 64'(obs.size()), 64'd3);
        if (obs.size() == 3) begin
            for (int k = 0; k < 3; k++)
                check("stall_order", 64'(obs[k].idx), 64'(12'h021 + k));
        end

        // Kill with two requests in flight and a new one offered.
        obs.delete();
        out_ready_i = 1'b0;
        send(12'h031);
        send(12'h032);
        step(1);
        @(negedge clk_i);
        check("prekill_out_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; in_idx_i = 12'h033; kill_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        check("kill_out_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_occupancy", 64'(occupancy_o), 64'd0);
        check("kill_out_valid_after", 64'(out_valid_o), 64'd0);
        step(10);
        check("kill_nothing_emerges", 64'(obs.size()), 64'd0);

        // Exception on resolve, then a clean request.
        obs.delete();
        mmu_tresp_ppn_i  = 20'h55555;
        mmu_tresp_xcpt_i = 1'b1;
        send(12'h041);
        step(2);
        mmu_tresp_xcpt_i = 1'b0;
        send(12'h042);
        step(10);
        check("xcpt_count", 64'(obs.size()), 64'd2);
        if (obs.size() == 2) begin
            check("xcpt_first_idx",  64'(obs[0].idx),  64'h041);
            check("xcpt_first_flag", 64'(obs[0].xcpt), 64'd1);
            check("xcpt_first_ppn",  64'(obs[0].ppn),  64'h55555);
            check("xcpt_second_flag", 64'(obs[1].xcpt), 64'd0);
        end

        // Reset mid-stream.
        mmu_tresp_ppn_i = 20'h12345;
        out_ready_i = 1'b0;
        send(12'h051);
        send(12'h052);
        step(1);
        rstn_i = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_occupancy", 64'(occupancy_o), 64'd0);
        check("midrst_in_ready",  64'(in_ready_o),  64'd1);
        check("midrst_out_idx",   64'(out_idx_o),   64'd0);
        step(2);
        rstn_i = 1'b1;
        out_ready_i = 1'b1;
        obs.delete();
        step(1);
        send(12'h061);
        t0 = fire_cyc;
        step(10);
        check("postrst_count", 64'(obs.size()), 64'd1);
        if (obs.size() == 1) begin
            check("postrst_idx", 64'(obs[0].idx), 64'h061);
            check("postrst_latency", 64'(obs[0].cyc - t0), 64'(DEPTH + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
